// File: rtl/core_store_buffer.sv
// Posted-write store buffer between the core data port and the downstream data bus.
// Writes are queued in order and drained at the downstream grant rate; reads pass only when the queue is empty.
module core_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up_rd_req,
  output logic                       up_rd_gnt,
  input  logic [AW-1:0]              up_rd_addr,
  output logic [DW-1:0]              up_rd_data,
  input  logic                       up_wr_req,
  output logic                       up_wr_gnt,
  input  logic [AW-1:0]              up_wr_addr,
  input  logic [DW-1:0]              up_wr_data,
  input  logic [DW/8-1:0]            up_wr_be,
  output logic                       dn_rd_req,
  input  logic                       dn_rd_gnt,
  output logic [AW-1:0]              dn_rd_addr,
  input  logic [DW-1:0]              dn_rd_data,
  output logic                       dn_wr_req,
  input  logic                       dn_wr_gnt,
  output logic [AW-1:0]              dn_wr_addr,
  output logic [DW-1:0]              dn_wr_data,
  output logic [DW/8-1:0]            dn_wr_be,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshake: a transfer happens in a cycle where req and gnt are both high;
  // read data arrives one cycle after that accepting cycle.

  logic [AW-1:0]   addr_mem [DEPTH];
  logic [DW-1:0]   data_mem [DEPTH];
  logic [DW/8-1:0] be_mem   [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          enq;
  logic          deq;

  // Grant is based on registered count only, so a full queue refuses a write
  // even when the head drains in the same cycle.
  assign up_wr_gnt = up_wr_req & (count < FULL);
  assign enq       = up_wr_gnt;
  assign dn_wr_req = (count != '0);
  assign deq       = dn_wr_req & dn_wr_gnt;

  assign dn_wr_addr = addr_mem[rptr];
  assign dn_wr_data = data_mem[rptr];
  assign dn_wr_be   = be_mem[rptr];

  // Reads only go out once every earlier write has drained.
  assign dn_rd_req  = up_rd_req & (count == '0);
  assign dn_rd_addr = up_rd_addr;
  assign up_rd_gnt  = dn_rd_req & dn_rd_gnt;
  assign up_rd_data = dn_rd_data;

  assign o_count = count;
  assign o_empty = (count == '0);

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wptr] <= up_wr_addr;
      data_mem[wptr] <= up_wr_data;
      be_mem[wptr]   <= up_wr_be;
    end
  end

  // Pointers are PW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_core_store_buffer.sv
// Bench for core_store_buffer: a per-cycle reference model with an ordered
// expected-write queue, plus directed checks at the interesting corners.
module tb_core_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int W     = AW + DW + DW/8;

  logic            clk;
  logic            rst;
  logic            up_rd_req;
  logic            up_rd_gnt;
  logic [AW-1:0]   up_rd_addr;
  logic [DW-1:0]   up_rd_data;
  logic            up_wr_req;
  logic            up_wr_gnt;
  logic [AW-1:0]   up_wr_addr;
  logic [DW-1:0]   up_wr_data;
  logic [DW/8-1:0] up_wr_be;
  logic            dn_rd_req;
  logic            dn_rd_gnt;
  logic [AW-1:0]   dn_rd_addr;
  logic [DW-1:0]   dn_rd_data;
  logic            dn_wr_req;
  logic            dn_wr_gnt;
  logic [AW-1:0]   dn_wr_addr;
  logic [DW-1:0]   dn_wr_data;
  logic [DW/8-1:0] dn_wr_be;
  logic [2:0]      o_count;
  logic            o_empty;

  core_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .up_rd_req(up_rd_req), .up_rd_gnt(up_rd_gnt), .up_rd_addr(up_rd_addr), .up_rd_data(up_rd_data),
    .up_wr_req(up_wr_req), .up_wr_gnt(up_wr_gnt), .up_wr_addr(up_wr_addr),
    .up_wr_data(up_wr_data), .up_wr_be(up_wr_be),
    .dn_rd_req(dn_rd_req), .dn_rd_gnt(dn_rd_gnt), .dn_rd_addr(dn_rd_addr), .dn_rd_data(dn_rd_data),
    .dn_wr_req(dn_wr_req), .dn_wr_gnt(dn_wr_gnt), .dn_wr_addr(dn_wr_addr),
    .dn_wr_data(dn_wr_data), .dn_wr_be(dn_wr_be),
    .o_count(o_count), .o_empty(o_empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int drained  = 0;
  int m_count  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: evaluates outputs mid-cycle, then advances to the next edge.
  always @(negedge clk) begin
    logic exp_gnt;
    logic exp_deq;
    exp_gnt = up_wr_req && (m_count < DEPTH);
    exp_deq = (m_count != 0) && dn_wr_gnt;
    check("wr_gnt",    up_wr_gnt, exp_gnt);
    check("count",     o_count, m_count);
    check("empty",     o_empty, m_count == 0);
    check("dn_wr_req", dn_wr_req, m_count != 0);
    check("dn_rd_req", dn_rd_req, up_rd_req && (m_count == 0));
    check("up_rd_gnt", up_rd_gnt, up_rd_req && (m_count == 0) && dn_rd_gnt);
    check("dn_rd_addr", dn_rd_addr, up_rd_addr);
    if (m_count != 0) check("head", {dn_wr_addr, dn_wr_data, dn_wr_be}, exp_q[0]);
    if (exp_deq) begin
      void'(exp_q.pop_front());
      drained++;
    end
    if (exp_gnt) exp_q.push_back({up_wr_addr, up_wr_data, up_wr_be});
    m_count = m_count + int'(exp_gnt) - int'(exp_deq);
    if (rst) begin
      exp_q.delete();
      m_count = 0;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    up_wr_req  = 1'b1;
    up_wr_addr = a;
    up_wr_data = d;
    up_wr_be   = be;
    step();
    up_wr_req  = 1'b0;
  endtask

  task automatic drain(input int n);
    dn_wr_gnt = 1'b1;
    repeat (n) step();
    dn_wr_gnt = 1'b0;
  endtask

  initial begin
    int d0;
    rst = 1'b1; up_rd_req = 0; up_rd_addr = '0; up_wr_req = 0; up_wr_addr = '0;
    up_wr_data = '0; up_wr_be = '0; dn_rd_gnt = 0; dn_rd_data = '0; dn_wr_gnt = 0;
    step(); step();
    rst = 1'b0;
    check("rst_empty", o_empty, 1'b1);
    check("rst_count", o_count, 3'd0);
    check("rst_dn_wr_req", dn_wr_req, 1'b0);
    check("rst_dn_rd_req", dn_rd_req, 1'b0);

    // 1: single write, one cycle to dn_wr_req, then drain
    up_wr_req = 1; up_wr_addr = 32'h100; up_wr_data = 32'hDEADBEEF; up_wr_be = 4'hF;
    #1 check("t1_gnt", up_wr_gnt, 1'b1);
    step(); up_wr_req = 0;
    check("t1_req", dn_wr_req, 1'b1);
    check("t1_head", {dn_wr_addr, dn_wr_data, dn_wr_be}, {32'h100, 32'hDEADBEEF, 4'hF});
    drain(1);
    check("t1_empty", o_empty, 1'b1);

    // 2: fill, fifth write refused, drain in order
    for (int i = 0; i < 4; i++) wr(32'(i * 4), $urandom, 4'($urandom_range(0, 15)));
    check("t2_count", o_count, 3'd4);
    up_wr_req = 1; up_wr_addr = 32'h10; up_wr_data = 32'h5;
    #1 check("t2_full_gnt", up_wr_gnt, 1'b0);
    step(); up_wr_req = 0;
    d0 = drained;
    drain(4);
    check("t2_drained", drained - d0, 4);
    check("t2_empty", o_empty, 1'b1);

    // 3: read behind a pending write stalls until the write drains
    wr(32'h200, 32'hA5A5A5A5, 4'hF);
    up_rd_req = 1; up_rd_addr = 32'h200; dn_rd_gnt = 1;
    #1 check("t3_rd_gnt_stall", up_rd_gnt, 1'b0);
    check("t3_dn_rd_stall", dn_rd_req, 1'b0);
    dn_wr_gnt = 1;
    step(); dn_wr_gnt = 0;
    check("t3_dn_rd_req", dn_rd_req, 1'b1);
    check("t3_rd_gnt", up_rd_gnt, 1'b1);
    step(); up_rd_req = 0; dn_rd_gnt = 0; dn_rd_data = 32'h12345678;
    #1 check("t3_rd_data", up_rd_data, 32'h12345678);
    dn_rd_data = '0;

    // 4: steady concurrent enqueue/dequeue at count 2 across pointer wrap
    wr(32'h300, $urandom, 4'hF);
    wr(32'h304, $urandom, 4'h3);
    d0 = drained;
    dn_wr_gnt = 1;
    for (int i = 0; i < 10; i++) begin
      up_wr_req = 1; up_wr_addr = 32'h400 + 32'(i * 4);
      up_wr_data = $urandom; up_wr_be = 4'($urandom_range(0, 15));
      step();
      check("t4_count", o_count, 3'd2);
    end
    up_wr_req = 0;
    drain(2);
    check("t4_drained", drained - d0, 12);

    // 5: full with drain in the same cycle still refuses the write
    for (int i = 0; i < 4; i++) wr(32'h500 + 32'(i * 4), $urandom, 4'hF);
    dn_wr_gnt = 1; up_wr_req = 1; up_wr_addr = 32'h600; up_wr_data = 32'h66;
    #1 check("t5_full_gnt", up_wr_gnt, 1'b0);
    step();
    check("t5_count", o_count, 3'd3);
    check("t5_gnt", up_wr_gnt, 1'b1);
    step(); up_wr_req = 0;
    drain(3);
    check("t5_empty", o_empty, 1'b1);

    // 6: reset mid-drain discards queue; later write drains cleanly
    for (int i = 0; i < 3; i++) wr(32'h700 + 32'(i * 4), $urandom, 4'hF);
    dn_wr_gnt = 1; rst = 1;
    step(); rst = 0; dn_wr_gnt = 0;
    check("t6_count", o_count, 3'd0);
    check("t6_dn_wr_req", dn_wr_req, 1'b0);
    step();
    check("t6_idle", dn_wr_req, 1'b0);
    wr(32'h40, 32'hCAFE, 4'b0011);
    check("t6_head", {dn_wr_addr, dn_wr_data, dn_wr_be}, {32'h40, 32'hCAFE, 4'b0011});
    drain(1);
    check("t6_empty", o_empty, 1'b1);

    // random mix of writes and drains
    for (int i = 0; i < 200; i++) begin
      up_wr_req  = 1'($urandom_range(0, 1));
      up_wr_addr = $urandom; up_wr_data = $urandom; up_wr_be = 4'($urandom_range(0, 15));
      dn_wr_gnt  = 1'($urandom_range(0, 1));
      step();
    end
    up_wr_req = 0;
    drain(DEPTH);
    check("rand_empty", o_empty, 1'b1);
    step();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
